// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and entry layout for the fetch-to-decode queue.
package fetch_pkg;
    localparam int PC_WIDTH = 39;
    localparam int EXCEPTION_CAUSE_WIDTH = 4;
    localparam int FDQ_DEPTH = 8;
    localparam int PTR_W = $clog2(FDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] next_pc;
        logic [PC_WIDTH-1:0] predict_pc;
        logic [31:0] instruction;
        logic is_rv;
        logic exception_valid;
        logic [EXCEPTION_CAUSE_WIDTH-1:0] ecause;
    } fdq_entry_t;

    function automatic logic [CNT_W-1:0] slots(input logic a, input logic b);
        return CNT_W'(a) + CNT_W'(b);
    endfunction
endpackage

// File: rtl/fetch_decode_queue_if.sv
// fetch_decode_queue_if: fetch-side and decode-side handshakes of the instruction queue.
interface fetch_decode_queue_if;
    import fetch_pkg::*;
    logic flush;
    logic first_vld;
    logic second_vld;
    fdq_entry_t first;
    fdq_entry_t second;
    logic single_rdy;
    logic double_rdy;
    logic dec_first_vld;
    logic dec_second_vld;
    logic dec_first_rdy;
    logic dec_second_rdy;
    fdq_entry_t dec_first;
    fdq_entry_t dec_second;
    logic [CNT_W-1:0] count;
    logic empty;

    modport master (
        output flush, first_vld, second_vld, first, second, dec_first_rdy, dec_second_rdy,
        input single_rdy, double_rdy, dec_first_vld, dec_second_vld, dec_first, dec_second, count, empty
    );
    modport slave (
        input flush, first_vld, second_vld, first, second, dec_first_rdy, dec_second_rdy,
        output single_rdy, double_rdy, dec_first_vld, dec_second_vld, dec_first, dec_second, count, empty
    );
endinterface

// File: rtl/fdq_mem_2w2r.sv
// fdq_mem_2w2r: entry array with two adjacent write ports and two async read ports.
module fdq_mem_2w2r
    import fetch_pkg::*;
(
    input  logic clk,
    input  logic we0,
    input  logic we1,
    input  logic [PTR_W-1:0] waddr,
    input  logic [PTR_W-1:0] raddr,
    input  fdq_entry_t wdata0,
    input  fdq_entry_t wdata1,
    output fdq_entry_t rdata0,
    output fdq_entry_t rdata1
);
    fdq_entry_t mem [FDQ_DEPTH];
    logic [PTR_W-1:0] waddr1;
    logic [PTR_W-1:0] raddr1;

    always_comb begin
        waddr1 = waddr + PTR_W'(1);
        raddr1 = raddr + PTR_W'(1);
        rdata0 = mem[raddr];
        rdata1 = mem[raddr1];
    end

    always_ff @(posedge clk) begin
        if (we0) mem[waddr] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end
endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: dual-issue in-order instruction buffer between fetch and decode.
module fetch_decode_queue
    import fetch_pkg::*;
(
    input logic clk,
    input logic rst,
    fetch_decode_queue_if.slave bus
);
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic wr0, wr1, pop0, pop1;
    fdq_entry_t rd0, rd1;

    // Readies look only at the registered count so decode rdy never reaches fetch rdy.
    always_comb begin
        bus.single_rdy = ~rst & (cnt < CNT_W'(FDQ_DEPTH));
        bus.double_rdy = ~rst & (cnt < CNT_W'(FDQ_DEPTH - 1));
        bus.dec_first_vld = ~rst & ~bus.flush & (cnt != '0);
        bus.dec_second_vld = ~rst & ~bus.flush & (cnt > CNT_W'(1));
        wr0 = bus.first_vld & bus.single_rdy & ~bus.flush;
        wr1 = wr0 & bus.second_vld & bus.double_rdy;
        pop0 = bus.dec_first_vld & bus.dec_first_rdy;
        pop1 = pop0 & bus.dec_second_vld & bus.dec_second_rdy;
        bus.dec_first = bus.dec_first_vld ? rd0 : '0;
        bus.dec_second = bus.dec_second_vld ? rd1 : '0;
        bus.count = rst ? '0 : cnt;
        bus.empty = bus.count == '0;
    end

    fdq_mem_2w2r u_mem (
        .clk(clk),
        .we0(wr0),
        .we1(wr1),
        .waddr(wr_ptr),
        .raddr(rd_ptr),
        .wdata0(bus.first),
        .wdata1(bus.second),
        .rdata0(rd0),
        .rdata1(rd1)
    );

    always_ff @(posedge clk) begin
        if (rst | bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(slots(wr0, wr1));
            rd_ptr <= rd_ptr + PTR_W'(slots(pop0, pop1));
            cnt <= cnt + slots(wr0, wr1) - slots(pop0, pop1);
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed and random stimulus against a queue-based reference model.
module tb_fetch_decode_queue;
    import fetch_pkg::*;
    logic clk = 0;
    logic rst = 1;
    int passed = 0;
    int total = 0;
    fdq_entry_t q[$];

    always #5 clk = ~clk;

    fetch_decode_queue_if bus();
    fetch_decode_queue dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic fdq_entry_t mk(input logic [PC_WIDTH-1:0] pc, input logic rv, input logic [31:0] ins);
        fdq_entry_t e;
        e.pc = pc;
        e.next_pc = pc + PC_WIDTH'(rv ? 4 : 2);
        e.predict_pc = e.next_pc;
        e.instruction = ins;
        e.is_rv = rv;
        e.exception_valid = 1'b0;
        e.ecause = '0;
        return e;
    endfunction

    function automatic fdq_entry_t rnd();
        fdq_entry_t e;
        e.pc = PC_WIDTH'({$urandom, $urandom});
        e.next_pc = PC_WIDTH'({$urandom, $urandom});
        e.predict_pc = PC_WIDTH'({$urandom, $urandom});
        e.instruction = $urandom;
        e.is_rv = 1'($urandom);
        e.exception_valid = 1'($urandom);
        e.ecause = EXCEPTION_CAUSE_WIDTH'($urandom);
        return e;
    endfunction

    task automatic drive(input logic f, input logic v0, input logic v1, input fdq_entry_t a,
                         input fdq_entry_t b, input logic r0, input logic r1);
        bus.flush = f;
        bus.first_vld = v0;
        bus.second_vld = v1;
        bus.first = a;
        bus.second = b;
        bus.dec_first_rdy = r0;
        bus.dec_second_rdy = r1;
    endtask

    task automatic idle(input logic r0, input logic r1);
        drive(0, 0, 0, '0, '0, r0, r1);
    endtask

    task automatic pair(input logic [PC_WIDTH-1:0] pc0, input logic [PC_WIDTH-1:0] pc1, input logic rv,
                        input logic [31:0] ins, input logic r0, input logic r1);
        drive(0, 1, 1, mk(pc0, rv, ins), mk(pc1, rv, ins), r0, r1);
    endtask

    // Check every output against the model, then advance the model at the clock edge.
    task automatic step();
        int n;
        logic sr, dr, v0, v1;
        fdq_entry_t e0, e1;
        n = q.size();
        #1;
        sr = !rst && n < FDQ_DEPTH;
        dr = !rst && n <= FDQ_DEPTH - 2;
        v0 = !rst && !bus.flush && n >= 1;
        v1 = !rst && !bus.flush && n >= 2;
        e0 = v0 ? q[0] : '0;
        e1 = v1 ? q[1] : '0;
        check("single_rdy", bus.single_rdy, sr);
        check("double_rdy", bus.double_rdy, dr);
        check("dec_first_vld", bus.dec_first_vld, v0);
        check("dec_second_vld", bus.dec_second_vld, v1);
        check("dec_first", bus.dec_first, e0);
        check("dec_second", bus.dec_second, e1);
        check("count", bus.count, rst ? 0 : n);
        check("empty", bus.empty, rst || n == 0);
        @(posedge clk);
        if (rst || bus.flush) q.delete();
        else begin
            if (v0 && bus.dec_first_rdy) begin
                void'(q.pop_front());
                if (v1 && bus.dec_second_rdy) void'(q.pop_front());
            end
            if (bus.first_vld && sr) begin
                q.push_back(bus.first);
                if (bus.second_vld && dr) q.push_back(bus.second);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle(0, 0);
        @(negedge clk);
        rst = 1;
        repeat (3) step();
        rst = 0;
        idle(1, 1);
        #1;
        check("rst_single_rdy", bus.single_rdy, 1);
        check("rst_double_rdy", bus.double_rdy, 1);
        check("rst_empty", bus.empty, 1);
        check("rst_count", bus.count, 0);
        check("rst_dec_vld", {bus.dec_first_vld, bus.dec_second_vld}, 0);
        step();

        pair(0, 4, 1, 32'haaa3aaa3, 1, 1);
        step();
        idle(1, 1);
        #1;
        check("pair_vld", {bus.dec_first_vld, bus.dec_second_vld}, 2'b11);
        check("pair_pc0", bus.dec_first.pc, 0);
        check("pair_pc1", bus.dec_second.pc, 4);
        step();
        #1;
        check("pair_empty", bus.empty, 1);
        step();

        for (int i = 0; i < 4; i++) begin
            pair(PC_WIDTH'('h10 + 8 * i), PC_WIDTH'('h14 + 8 * i), 1, 32'h00000013, 0, 0);
            step();
        end
        pair('h30, 'h34, 1, 32'h00000013, 0, 0);
        #1;
        check("full_count", bus.count, 8);
        check("full_rdys", {bus.single_rdy, bus.double_rdy}, 2'b00);
        step();
        idle(0, 0);
        #1;
        check("full_drop_count", bus.count, 8);
        check("full_head_pc", bus.dec_first.pc, 'h10);
        step();

        idle(1, 0);
        step();
        drive(0, 1, 1, mk('h40, 0, 32'h0000aaa0), mk('h42, 0, 32'h0000aaa0), 0, 0);
        #1;
        check("m1_count", bus.count, 7);
        check("m1_rdys", {bus.single_rdy, bus.double_rdy}, 2'b10);
        step();
        idle(0, 0);
        #1;
        check("m1_after_count", bus.count, 8);
        step();

        drive(1, 0, 0, '0, '0, 0, 0);
        step();
        pair('h100, 'h104, 1, 32'h00000013, 0, 0);
        step();
        drive(0, 1, 0, mk('h108, 1, 32'h00000013), '0, 0, 0);
        step();
        idle(0, 1);
        step();
        idle(1, 0);
        #1;
        check("order_hold", bus.count, 3);
        step();
        idle(0, 0);
        #1;
        check("order_one", bus.count, 2);
        check("order_head", bus.dec_first.pc, 'h104);
        step();

        pair('h200, 'h204, 1, 32'h00000013, 0, 0);
        step();
        drive(0, 1, 0, mk('h208, 1, 32'h00000013), '0, 0, 0);
        step();
        drive(1, 1, 1, mk('h300, 1, 32'h1), mk('h304, 1, 32'h2), 1, 1);
        #1;
        check("flush_count_before", bus.count, 5);
        check("flush_vld", {bus.dec_first_vld, bus.dec_second_vld}, 2'b00);
        step();
        pair('hc, 'h10, 1, 32'h00000013, 0, 0);
        #1;
        check("flush_count", bus.count, 0);
        check("flush_empty", bus.empty, 1);
        step();
        idle(0, 0);
        #1;
        check("flush_head", bus.dec_first.pc, 'hc);
        step();

        for (int i = 0; i < 1500; i++) begin
            int ph;
            ph = (i / 100) % 3;
            rst = $urandom_range(0, 63) == 0;
            drive($urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom), rnd(), rnd(),
                  $urandom_range(0, 3) < ph + 1, $urandom_range(0, 3) < ph + 1);
            step();
        end
        rst = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
